// File: rtl/mod_ex_mc_if.sv
// Execute-stage bundle: upstream operation/handshake, forwarding sources and the
// downstream result slot. The stage uses the slave view, the feeding logic the master view.
interface mod_ex_mc_if #(
  parameter int WIDTH = 16,
  parameter int NFWD  = 2,
  parameter int FSW   = $clog2(NFWD + 1)
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              aluop;
  logic                    alusrc;
  logic                    memenable;
  logic                    keep_flag;
  logic [FSW-1:0]          fwd_sel_a;
  logic [FSW-1:0]          fwd_sel_b;
  logic [NFWD*WIDTH-1:0]   fwd_data;
  logic [WIDTH-1:0]        src_a;
  logic [WIDTH-1:0]        src_b;
  logic [WIDTH-1:0]        imm;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        result;
  logic [2:0]              flags;
  logic                    busy;

  modport slave (
    input  flush, in_valid, aluop, alusrc, memenable, keep_flag,
           fwd_sel_a, fwd_sel_b, fwd_data, src_a, src_b, imm, out_ready,
    output in_ready, out_valid, result, flags, busy
  );

  modport master (
    output flush, in_valid, aluop, alusrc, memenable, keep_flag,
           fwd_sel_a, fwd_sel_b, fwd_data, src_a, src_b, imm, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/mod_ex_mc.sv
// Execute stage: operand forwarding, address-mode operands, single-cycle ALU and an
// iterative shift-add multiplier feeding one registered result slot with NVZ flags.
module mod_ex_mc #(
  parameter int WIDTH = 16,
  parameter int NFWD  = 2,
  parameter int FSW   = $clog2(NFWD + 1)
) (
  input logic        clk,
  input logic        rst,
  mod_ex_mc_if.slave ex
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_SLL = 4'd5, OP_SRA = 4'd6, OP_ROR = 4'd7, OP_MUL = 4'd8
  } alu_op_e;

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_e;

  // Select 0 and any select above NFWD both fall back to the register operand.
  function automatic logic [WIDTH-1:0] fwd_pick(input logic [FSW-1:0]        sel,
                                               input logic [WIDTH-1:0]      src,
                                               input logic [NFWD*WIDTH-1:0] data);
    logic [WIDTH-1:0] v;
    v = src;
    for (int k = 1; k <= NFWD; k++)
      if (sel == FSW'(k)) v = data[(k-1)*WIDTH +: WIDTH];
    return v;
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] result_q, acc_q, mcand_q, mplier_q;
  logic [2:0]       flags_q;
  logic             out_valid_q, busy_q, mul_keep_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] fwd_a, fwd_b, op_a, op_b, imm_eff, sum_res, diff_res, alu_res;
  logic [SHW-1:0]   shamt;
  logic             alu_v, wr_nv, wr_z, slot_free, in_ready, accept, mul_last;
  logic [2:0]       alu_flags;

  assign fwd_a    = fwd_pick(ex.fwd_sel_a, ex.src_a, ex.fwd_data);
  assign fwd_b    = fwd_pick(ex.fwd_sel_b, ex.src_b, ex.fwd_data);
  assign op_a     = ex.memenable ? {fwd_a[WIDTH-1:1], 1'b0} : fwd_a;
  assign imm_eff  = ex.memenable ? {ex.imm[WIDTH-2:0], 1'b0} : ex.imm;
  assign op_b     = ex.alusrc ? imm_eff : fwd_b;
  assign shamt    = op_b[SHW-1:0];
  assign sum_res  = op_a + op_b;
  assign diff_res = op_a - op_b;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    alu_res = '0;
    alu_v   = 1'b0;
    wr_nv   = 1'b0;
    wr_z    = 1'b0;
    case (ex.aluop)
      OP_ADD: begin
        alu_res = sum_res;
        alu_v   = (op_a[MSB] == op_b[MSB]) && (sum_res[MSB] != op_a[MSB]);
        wr_nv   = 1'b1;
        wr_z    = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff_res;
        alu_v   = (op_a[MSB] != op_b[MSB]) && (diff_res[MSB] != op_a[MSB]);
        wr_nv   = 1'b1;
        wr_z    = 1'b1;
      end
      OP_AND: begin alu_res = op_a & op_b;                      wr_z = 1'b1; end
      OP_OR:  begin alu_res = op_a | op_b;                      wr_z = 1'b1; end
      OP_XOR: begin alu_res = op_a ^ op_b;                      wr_z = 1'b1; end
      OP_SLL: begin alu_res = op_a << shamt;                    wr_z = 1'b1; end
      OP_SRA: begin alu_res = $signed(op_a) >>> shamt;          wr_z = 1'b1; end
      OP_ROR: begin alu_res = WIDTH'({op_a, op_a} >> shamt);    wr_z = 1'b1; end
      default: ;
    endcase

    alu_flags = flags_q;
    if (!ex.keep_flag) begin
      if (wr_nv) alu_flags[2:1] = {alu_res[MSB], alu_v};
      if (wr_z)  alu_flags[0]   = (alu_res == '0);
    end
  end

  assign slot_free = !out_valid_q || ex.out_ready;
  assign in_ready  = (state_q == S_IDLE) && slot_free && !ex.flush;
  assign accept    = ex.in_valid && in_ready;
  assign mul_last  = (cnt_q == CW'(WIDTH));

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      flags_q     <= 3'b000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mul_keep_q  <= 1'b0;
    end else if (ex.flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (out_valid_q && ex.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && ex.aluop == OP_MUL) begin
            mcand_q    <= op_a;
            mplier_q   <= op_b;
            acc_q      <= '0;
            cnt_q      <= '0;
            mul_keep_q <= ex.keep_flag;
            busy_q     <= 1'b1;
            state_q    <= S_MUL_BUSY;
          end else if (accept) begin
            result_q    <= alu_res;
            flags_q     <= alu_flags;
            out_valid_q <= 1'b1;
          end
        end
        S_MUL_BUSY: begin
          if (!mul_last) begin
            // Low WIDTH product bits are identical for signed and unsigned operands.
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            busy_q   <= (cnt_q != CW'(WIDTH - 1));
          end else if (slot_free) begin
            result_q    <= acc_q;
            out_valid_q <= 1'b1;
            if (!mul_keep_q) flags_q[0] <= (acc_q == '0);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex.in_ready  = in_ready;
  assign ex.out_valid = out_valid_q;
  assign ex.result    = result_q;
  assign ex.flags     = flags_q;
  assign ex.busy      = busy_q;
endmodule
